zx_mem_pager: RTL and testbench
===============================

// Module: zx_mem_pager
// PURPOSE
// - Parametrised successor to the fixed 16K/48K memory decoder: 128K-style banked memory controller on the Z80 bus.
// - Decodes CPU memory cycles into ROM page / RAM bank accesses on external SRAM, and owns the paging register (IO 0x7FFD style, lockable).
// - Drives nWAIT through a wait-state FSM for slow SRAM and exports the screen-bank select to the ULA.
// - Sits between the z80_top_direct_n bus (A/D/strobes) and the rom/SRAM/ULA video path. All bus inputs are synchronous to clk_vram.
// PARAMETERS
// - RAM_BANKS  8        number of 16K RAM banks (1..8); bank index is taken modulo RAM_BANKS
// - ROM_PAGES  2        number of 16K ROM pages (1 or 2)
// - SRAM_WAIT  2        clk_vram cycles the SRAM strobe is held per access (1..15)
// - PAGE_MASK  16'h8002 IO address bits decoded for the paging port
// - PAGE_MATCH 16'h0000 required value of the masked bits (A15=0, A1=0)
// PORTS
// - clk_vram     in   1   memory/pixel clock; every register is clocked here
// - reset        in   1   synchronous, active-high
// - A            in   16  CPU address bus
// - D_in         in   8   CPU write data
// - nMREQ,nIORQ,nRD,nWR,nRFSH in 1 each  Z80 strobes, active-low
// - mem_q        out  8   read data to the bus mux; valid when mem_oe=1
// - mem_oe       out  1   high while a memory read holds valid data
// - nWAIT        out  1   Z80 wait request, active-low
// - rom_addr     out  15  {rom_page, A[13:0]}
// - rom_q        in   8   ROM data, 1-cycle registered latency
// - sram_addr    out  14+$clog2(RAM_BANKS)  {bank, A[13:0]}
// - sram_dq_o    out  8   SRAM write data
// - sram_dq_i    in   8   SRAM read data
// - sram_oe_n, sram_we_n  out 1 each  SRAM strobes, active-low
// - screen_sel   out  1   0 = bank 5, 1 = bank 7 is the displayed screen
// - page_reg     out  6   current paging register, for debug/LEDs
// BEHAVIOUR
// - Reset values: page_reg=0, screen_sel=0, mem_q=0, mem_oe=0, nWAIT=1, sram_oe_n=1, sram_we_n=1, FSM=IDLE.
// - Map: 0000-3FFF ROM page page_reg[4]; 4000-7FFF bank 5; 8000-BFFF bank 2; C000-FFFF bank page_reg[2:0]%RAM_BANKS.
// - Start condition: nMREQ=0, nRFSH=1, (nRD=0 or nWR=0), FSM in IDLE. Refresh cycles never start an access.
// - FSM IDLE->ACCESS (count=SRAM_WAIT)->DONE->IDLE.
//   - ACCESS: nWAIT=0; read asserts sram_oe_n (or rom path); write asserts sram_we_n with sram_dq_o=D_in held stable.
//   - Count decrements each cycle. At count==1, read data is registered into mem_q.
//   - DONE: nWAIT=1, mem_oe=1 for reads, strobes released. Stays in DONE until nMREQ=1, then IDLE with mem_oe=0.
// - Read latency: mem_q valid SRAM_WAIT+1 cycles after the start cycle. The nWAIT rise and mem_oe rise happen in the same cycle.
// - ROM accesses use the same FSM timing. Writes to 0000-3FFF enter ACCESS but keep sram_we_n=1 (write discarded).
// - Paging write: nIORQ=0, nWR=0, (A & PAGE_MASK)==PAGE_MATCH, page_reg[5]=0.
//   - Edge-detected: loads page_reg<=D_in[5:0] exactly once per IO cycle.
//   - page_reg[3] drives screen_sel the following cycle.
// - Lock: once page_reg[5]=1, further paging writes are ignored until reset. The lock bit itself is writable in the same write that sets it.
// - Bank switch during a memory access: sram_addr is latched at start. A page write mid-access affects only the next access.
// - Reset mid-access: next cycle FSM=IDLE, nWAIT=1, both SRAM strobes high, no partial write completes.
// - ROM_PAGES=1: page_reg[4] is stored but rom_addr[14] is forced 0.
// STRUCTURE
// - Package zx_mem_pkg:
//   - typedef struct packed page_reg_t {lock, rom, scr, bank[2:0]}.
//   - enum mem_state_t {IDLE, ACCESS, DONE}.
//   - localparams BANK_SCREEN0=5, BANK_SCREEN1=7, BANK_FIXED=2, PAGE_BITS=6.
// - One sub-module, zx_page_reg: IO decode, write edge detect, lock handling, screen_sel.
// - Address mapping and the wait-state FSM stay in zx_mem_pager.
// TESTING
// - Reset, then read 0x0000 -> rom_addr=0x0000, nWAIT low for 2 cycles, mem_q=rom_q at cycle 3, mem_oe=1.
// - Out 0x7FFD<-0x03, write 0xAA to 0xC000 -> sram_addr={3'd3,14'h0}, we_n low 2 cycles; readback=0xAA.
// - Out 0x7FFD<-0x18 -> screen_sel=1, rom_addr[14]=1. Then out 0x7FFD<-0x20 (lock), then out 0x7FFD<-0x07 -> page_reg stays 0x20.
// - Write 0x55 to 0x1234 -> sram_we_n never low, nWAIT still pulses for SRAM_WAIT cycles.
// - nRFSH=0 with nMREQ=0 -> FSM stays IDLE, nWAIT=1, no strobes.
// - Assert reset on cycle 1 of a write -> next cycle sram_we_n=1, nWAIT=1, page_reg=0. Repeat with SRAM_WAIT=5 and RAM_BANKS=4 (bank 6 maps to 2).

Source files
------------

// File: rtl/zx_mem_pkg.sv
// Shared types and constants for the banked Z80 memory pager.
package zx_mem_pkg;

  localparam int unsigned BANK_SCREEN0 = 5;
  localparam int unsigned BANK_SCREEN1 = 7;
  localparam int unsigned BANK_FIXED   = 2;
  localparam int unsigned PAGE_BITS    = 6;

  typedef struct packed {
    logic       lock;
    logic       rom;
    logic       scr;
    logic [2:0] bank;
  } page_reg_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

  // Fold a logical 16K bank number onto the banks actually fitted.
  function automatic logic [2:0] bank_mod(input logic [2:0] bank, input int unsigned banks);
    return 3'(32'(bank) % banks);
  endfunction

endpackage

// File: rtl/zx_page_reg.sv
// Paging port: IO write decode, one load per IO cycle, lock bit and screen select.
module zx_page_reg
  import zx_mem_pkg::*;
#(
  parameter logic [15:0] PAGE_MASK  = 16'h8002,
  parameter logic [15:0] PAGE_MATCH = 16'h0000
) (
  input  logic        clk_vram,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [5:0]  data,
  input  logic        nIORQ,
  input  logic        nWR,
  output page_reg_t   page,
  output logic        screen_sel
);

  logic io_wr;
  logic io_wr_q;

  always_comb io_wr = !nIORQ && !nWR && ((A & PAGE_MASK) == PAGE_MATCH);

  always_ff @(posedge clk_vram) begin
    if (reset) begin
      page       <= '0;
      io_wr_q    <= 1'b0;
      screen_sel <= 1'b0;
    end else begin
      io_wr_q <= io_wr;
      // Load only on the first cycle of the IO write; the lock bit can set itself.
      if (io_wr && !io_wr_q && !page.lock)
        page <= page_reg_t'(data);
      screen_sel <= page.scr;
    end
  end

endmodule

// File: rtl/zx_mem_pager.sv
// 128K-style banked memory controller: address map, wait-state FSM and SRAM/ROM strobes.
module zx_mem_pager
  import zx_mem_pkg::*;
#(
  parameter int unsigned RAM_BANKS  = 8,
  parameter int unsigned ROM_PAGES  = 2,
  parameter int unsigned SRAM_WAIT  = 2,
  parameter logic [15:0] PAGE_MASK  = 16'h8002,
  parameter logic [15:0] PAGE_MATCH = 16'h0000
) (
  input  logic                            clk_vram,
  input  logic                            reset,
  input  logic [15:0]                     A,
  input  logic [7:0]                      D_in,
  input  logic                            nMREQ,
  input  logic                            nIORQ,
  input  logic                            nRD,
  input  logic                            nWR,
  input  logic                            nRFSH,
  output logic [7:0]                      mem_q,
  output logic                            mem_oe,
  output logic                            nWAIT,
  output logic [14:0]                     rom_addr,
  input  logic [7:0]                      rom_q,
  output logic [14+$clog2(RAM_BANKS)-1:0] sram_addr,
  output logic [7:0]                      sram_dq_o,
  input  logic [7:0]                      sram_dq_i,
  output logic                            sram_oe_n,
  output logic                            sram_we_n,
  output logic                            screen_sel,
  output logic [PAGE_BITS-1:0]            page_reg
);

  localparam int unsigned SRAM_AW = 14 + $clog2(RAM_BANKS);

  mem_state_t         state, state_nx;
  page_reg_t          page;
  logic [3:0]         count;
  logic               start;
  logic [2:0]         bank_raw;
  logic [SRAM_AW-1:0] sram_addr_now, lat_sram;
  logic [14:0]        rom_addr_now, lat_rom_addr;
  logic               lat_wr, lat_rom;
  logic [7:0]         lat_d;

  zx_page_reg #(
    .PAGE_MASK (PAGE_MASK),
    .PAGE_MATCH(PAGE_MATCH)
  ) u_page_reg (
    .clk_vram  (clk_vram),
    .reset     (reset),
    .A         (A),
    .data      (D_in[5:0]),
    .nIORQ     (nIORQ),
    .nWR       (nWR),
    .page      (page),
    .screen_sel(screen_sel)
  );

  always_comb start = !nMREQ && nRFSH && (!nRD || !nWR);

  always_comb begin
    unique case (A[15:14])
      2'b01:   bank_raw = 3'(BANK_SCREEN0);
      2'b10:   bank_raw = 3'(BANK_FIXED);
      2'b11:   bank_raw = page.bank;
      default: bank_raw = '0;
    endcase
    sram_addr_now = SRAM_AW'({bank_mod(bank_raw, RAM_BANKS), A[13:0]});
    rom_addr_now  = {(ROM_PAGES > 1) ? page.rom : 1'b0, A[13:0]};
  end

  always_ff @(posedge clk_vram) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ACCESS;
      ACCESS:  if (count == 4'd1) state_nx = DONE;
      DONE:    if (nMREQ) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address and write data are captured at start so a mid-access page write only hits the next access.
  always_ff @(posedge clk_vram) begin
    if (reset) begin
      count        <= '0;
      lat_wr       <= 1'b0;
      lat_rom      <= 1'b0;
      lat_sram     <= '0;
      lat_rom_addr <= '0;
      lat_d        <= '0;
      mem_q        <= '0;
    end else if (state == IDLE && start) begin
      count        <= 4'(SRAM_WAIT);
      lat_wr       <= !nWR;
      lat_rom      <= (A[15:14] == 2'b00);
      lat_sram     <= sram_addr_now;
      lat_rom_addr <= rom_addr_now;
      lat_d        <= D_in;
    end else if (state == ACCESS) begin
      count <= count - 4'd1;
      if (count == 4'd1 && !lat_wr)
        mem_q <= lat_rom ? rom_q : sram_dq_i;
    end
  end

  // ROM is addressed from the live bus while idle so its registered data is ready by the last wait cycle.
  always_comb begin
    nWAIT     = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    mem_oe    = 1'b0;
    rom_addr  = (state == IDLE) ? rom_addr_now : lat_rom_addr;
    sram_addr = (state == IDLE) ? sram_addr_now : lat_sram;
    sram_dq_o = lat_d;
    page_reg  = page;
    unique case (state)
      ACCESS: begin
        nWAIT = 1'b0;
        if (!lat_rom) begin
          if (lat_wr) sram_we_n = 1'b0;
          else        sram_oe_n = 1'b0;
        end
      end
      DONE:    mem_oe = !lat_wr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zx_mem_pager.sv
// Scoreboard bench for zx_mem_pager: two instances (8 banks/2 waits, 4 banks/5 waits).
module tb_zx_mem_pager;

  typedef struct {
    bit          wr;
    logic [7:0]  data;
    logic [16:0] addr;
    int unsigned we_cyc;
  } exp_t;

  localparam int KEY = 1 << 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic [15:0] a_bus     [2];
  logic [7:0]  d_bus     [2];
  logic        n_mreq    [2];
  logic        n_iorq    [2];
  logic        n_rd      [2];
  logic        n_wr      [2];
  logic        n_rfsh    [2];
  logic [7:0]  mem_q     [2];
  logic        mem_oe    [2];
  logic        n_wait    [2];
  logic [14:0] rom_addr  [2];
  logic [7:0]  rom_q     [2];
  logic [16:0] sram_addr [2];
  logic [7:0]  sram_dq_o [2];
  logic [7:0]  sram_dq_i [2];
  logic        sram_oe_n [2];
  logic        sram_we_n [2];
  logic        screen_sel[2];
  logic [5:0]  page_reg  [2];

  int checks   = 0;
  int failures = 0;

  exp_t       sb0[$];
  exp_t       sb1[$];
  logic [5:0] m_page[2];
  logic [7:0] m_mem[int];

  function automatic logic [7:0] rom_byte(input logic [14:0] a);
    return a[7:0] ^ {a[14:8], 1'b1} ^ 8'hA5;
  endfunction

  function automatic int unsigned rb_of(input int g);
    return (g == 0) ? 8 : 4;
  endfunction

  function automatic int unsigned sw_of(input int g);
    return (g == 0) ? 2 : 5;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned RBG = (g == 0) ? 8 : 4;
    localparam int unsigned SWG = (g == 0) ? 2 : 5;
    localparam int unsigned AW  = 14 + $clog2(RBG);
    logic [AW-1:0] sa;
    logic [7:0]    sram [0:(1<<AW)-1];

    zx_mem_pager #(
      .RAM_BANKS (RBG),
      .ROM_PAGES (2),
      .SRAM_WAIT (SWG),
      .PAGE_MASK (16'h8002),
      .PAGE_MATCH(16'h0000)
    ) dut (
      .clk_vram  (clk),
      .reset     (reset[g]),
      .A         (a_bus[g]),
      .D_in      (d_bus[g]),
      .nMREQ     (n_mreq[g]),
      .nIORQ     (n_iorq[g]),
      .nRD       (n_rd[g]),
      .nWR       (n_wr[g]),
      .nRFSH     (n_rfsh[g]),
      .mem_q     (mem_q[g]),
      .mem_oe    (mem_oe[g]),
      .nWAIT     (n_wait[g]),
      .rom_addr  (rom_addr[g]),
      .rom_q     (rom_q[g]),
      .sram_addr (sa),
      .sram_dq_o (sram_dq_o[g]),
      .sram_dq_i (sram_dq_i[g]),
      .sram_oe_n (sram_oe_n[g]),
      .sram_we_n (sram_we_n[g]),
      .screen_sel(screen_sel[g]),
      .page_reg  (page_reg[g])
    );

    assign sram_addr[g] = 17'(sa);
    assign sram_dq_i[g] = sram[sa];

    initial for (int i = 0; i < (1 << AW); i++) sram[i] = 8'h00;

    always @(posedge clk) begin
      if (!sram_we_n[g]) sram[sa] = sram_dq_o[g];
    end

    always @(posedge clk) rom_q[g] <= rom_byte(rom_addr[g]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference memory map written straight from the 16K-window rules.
  function automatic int phys_of(input int g, input logic [15:0] addr);
    int unsigned bank;
    case (addr[15:14])
      2'd1:    bank = 5;
      2'd2:    bank = 2;
      2'd3:    bank = int'(m_page[g][2:0]);
      default: bank = 0;
    endcase
    return int'((bank % rb_of(g)) * 16384 + int'(addr[13:0]));
  endfunction

  function automatic logic [7:0] mem_get(input int g, input int phys);
    int k;
    k = g * KEY + phys;
    return m_mem.exists(k) ? m_mem[k] : 8'h00;
  endfunction

  task automatic push(input int g, input exp_t e);
    if (g == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic monitor(input int g);
    int unsigned wait_cyc = 0;
    int unsigned we_cyc   = 0;
    logic [16:0] we_addr  = '0;
    bit          in_acc   = 0;
    bit          have;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset[g]) begin
        in_acc = 0;
        continue;
      end
      if (!n_wait[g]) begin
        if (!in_acc) begin
          in_acc   = 1;
          wait_cyc = 0;
          we_cyc   = 0;
        end
        wait_cyc++;
        if (!sram_we_n[g]) begin
          we_cyc++;
          we_addr = sram_addr[g];
        end
      end else if (in_acc) begin
        in_acc = 0;
        have   = 0;
        if (g == 0) begin
          have = sb0.size() > 0;
          if (have) e = sb0.pop_front();
        end else begin
          have = sb1.size() > 0;
          if (have) e = sb1.pop_front();
        end
        chk("expected_access", 32'(have), 32'd1);
        if (have) begin
          chk("wait_len", wait_cyc, sw_of(g));
          if (e.wr) begin
            chk("we_len", we_cyc, e.we_cyc);
            if (e.we_cyc != 0) chk("we_addr", 32'(we_addr), 32'(e.addr));
            chk("oe_on_write", 32'(mem_oe[g]), 32'd0);
          end else begin
            chk("oe_with_wait", 32'(mem_oe[g]), 32'd1);
            chk("rd_data", 32'(mem_q[g]), 32'(e.data));
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic mem_cycle(input int g, input logic [15:0] addr, input bit wr, input logic [7:0] data);
    exp_t e;
    int   phys;
    bit   rom;
    bit   seen;
    rom      = (addr[15:14] == 2'b00);
    phys     = phys_of(g, addr);
    e.wr     = wr;
    e.addr   = 17'(phys);
    e.data   = data;
    e.we_cyc = (wr && !rom) ? sw_of(g) : 0;
    if (!wr)
      e.data = rom ? rom_byte({m_page[g][4], addr[13:0]}) : mem_get(g, phys);
    else if (!rom)
      m_mem[g * KEY + phys] = data;
    push(g, e);
    @(negedge clk);
    a_bus[g]  = addr;
    d_bus[g]  = data;
    n_mreq[g] = 1'b0;
    if (wr) n_wr[g] = 1'b0;
    else    n_rd[g] = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!n_wait[g]) seen = 1;
      else if (seen) break;
    end
    chk("access_done", 32'(seen && n_wait[g]), 32'd1);
    @(negedge clk);
    n_mreq[g] = 1'b1;
    n_rd[g]   = 1'b1;
    n_wr[g]   = 1'b1;
    @(negedge clk);
  endtask

  // Data is corrupted after the first cycle to prove the register loads only once per IO cycle.
  task automatic io_write(input int g, input logic [15:0] addr, input logic [7:0] data);
    if (((addr & 16'h8002) == 16'h0000) && !m_page[g][5]) m_page[g] = data[5:0];
    @(negedge clk);
    a_bus[g]  = addr;
    d_bus[g]  = data;
    n_iorq[g] = 1'b0;
    n_wr[g]   = 1'b0;
    @(negedge clk);
    d_bus[g] = data ^ 8'h1F;
    repeat (2) @(negedge clk);
    n_iorq[g] = 1'b1;
    n_wr[g]   = 1'b1;
    @(negedge clk);
    chk("page_reg", 32'(page_reg[g]), 32'(m_page[g]));
    chk("screen_sel", 32'(screen_sel[g]), 32'(m_page[g][3]));
  endtask

  task automatic refresh_cycle(input int g);
    @(negedge clk);
    a_bus[g]  = 16'h8000;
    n_mreq[g] = 1'b0;
    n_rfsh[g] = 1'b0;
    n_rd[g]   = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rfsh_nwait", 32'(n_wait[g]), 32'd1);
      chk("rfsh_oe_n", 32'(sram_oe_n[g]), 32'd1);
      chk("rfsh_we_n", 32'(sram_we_n[g]), 32'd1);
    end
    n_mreq[g] = 1'b1;
    n_rfsh[g] = 1'b1;
    n_rd[g]   = 1'b1;
    @(negedge clk);
  endtask

  task automatic abort_write(input int g, input logic [15:0] addr);
    @(negedge clk);
    a_bus[g]  = addr;
    d_bus[g]  = 8'hE7;
    n_mreq[g] = 1'b0;
    n_wr[g]   = 1'b0;
    @(negedge clk);
    chk("abort_in_access", 32'(n_wait[g]), 32'd0);
    reset[g] = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_we_n", 32'(sram_we_n[g]), 32'd1);
    chk("abort_oe_n", 32'(sram_oe_n[g]), 32'd1);
    chk("abort_nwait", 32'(n_wait[g]), 32'd1);
    chk("abort_page", 32'(page_reg[g]), 32'd0);
    m_page[g] = '0;
    @(negedge clk);
    @(negedge clk);
    reset[g]  = 1'b0;
    n_mreq[g] = 1'b1;
    n_wr[g]   = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_abort_nwait", 32'(n_wait[g]), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ad;
    int          r;
    for (int g = 0; g < 2; g++) begin
      reset[g]  = 1'b1;
      a_bus[g]  = '0;
      d_bus[g]  = '0;
      n_mreq[g] = 1'b1;
      n_iorq[g] = 1'b1;
      n_rd[g]   = 1'b1;
      n_wr[g]   = 1'b1;
      n_rfsh[g] = 1'b1;
      m_page[g] = '0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_page", 32'(page_reg[g]), 32'd0);
      chk("rst_screen", 32'(screen_sel[g]), 32'd0);
      chk("rst_mem_q", 32'(mem_q[g]), 32'd0);
      chk("rst_mem_oe", 32'(mem_oe[g]), 32'd0);
      chk("rst_nwait", 32'(n_wait[g]), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n[g]), 32'd1);
      chk("rst_we_n", 32'(sram_we_n[g]), 32'd1);
    end

    mem_cycle(0, 16'h0000, 0, 8'h00);
    io_write(0, 16'h7FFD, 8'h03);
    mem_cycle(0, 16'hC000, 1, 8'hAA);
    mem_cycle(0, 16'hC000, 0, 8'h00);
    io_write(0, 16'h7FFD, 8'h18);
    mem_cycle(0, 16'h0000, 0, 8'h00);
    chk("rom_addr_page1", 32'(rom_addr[0][14]), 32'd1);
    mem_cycle(0, 16'h1234, 1, 8'h55);
    mem_cycle(0, 16'h1234, 0, 8'h00);
    refresh_cycle(0);
    io_write(0, 16'hFFFD, 8'h07);
    io_write(0, 16'h7FFF, 8'h07);

    for (int n = 0; n < 80; n++) begin
      r  = int'($urandom_range(0, 9));
      ad = {2'($urandom_range(0, 3)), 10'd0, 4'($urandom_range(0, 15))};
      if (r == 0)      io_write(0, 16'h7FFD, 8'($urandom()) & 8'h1F);
      else if (r == 1) io_write(0, ($urandom_range(0, 1) == 0) ? 16'hFFFD : 16'h7FFF, 8'($urandom()));
      else if (r < 5)  mem_cycle(0, ad, 1, 8'($urandom()));
      else             mem_cycle(0, ad, 0, 8'h00);
    end

    io_write(0, 16'h7FFD, 8'h20);
    io_write(0, 16'h7FFD, 8'h07);
    chk("lock_hold", 32'(page_reg[0]), 32'h20);
    abort_write(0, 16'hC3FF);

    io_write(1, 16'h7FFD, 8'h06);
    mem_cycle(1, 16'hC010, 1, 8'h77);
    mem_cycle(1, 16'h8010, 0, 8'h00);
    mem_cycle(1, 16'h4005, 1, 8'h3C);
    io_write(1, 16'h7FFD, 8'h01);
    mem_cycle(1, 16'hC005, 0, 8'h00);
    mem_cycle(1, 16'h2001, 0, 8'h00);
    mem_cycle(1, 16'h0100, 1, 8'h99);
    abort_write(1, 16'hC3FF);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb0.size() + sb1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
